// File: rtl/int2float_pipe_if.sv
// Handshake bundle for int2float_pipe: input stream (integer + tag) and output stream (float + tag + inexact).
// The master side is the producer/consumer pair; the slave side is the converter.
interface int2float_pipe_if #(
  parameter int INT_W = 16,
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [INT_W-1:0]       in_data;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   out_data;
  logic [TAG_W-1:0]       out_tag;
  logic                   out_inexact;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_inexact
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_inexact
  );
endinterface

// File: rtl/int2float_pipe.sv
// 3-stage two's-complement integer to {sign, exp, man} float converter with valid/ready and tag.
// Define INT2FLOAT_ROUND_EN for round-to-nearest-even; otherwise the magnitude is truncated.
module int2float_pipe #(
  parameter int INT_W = 16,
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  int2float_pipe_if.slave bus
);
  localparam int OUT_W = 1 + EXP_W + MAN_W;
  localparam int FR_W  = INT_W + MAN_W;

  if (INT_W < 2 || MAN_W < 1 || (2**EXP_W) - 1 < INT_W) begin : g_param_check
    $error("int2float_pipe: illegal INT_W/EXP_W/MAN_W combination");
  end

  logic             r_s1_valid, r_s1_sign;
  logic [INT_W-1:0] r_s1_mag;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s2_valid, r_s2_sign;
  logic [EXP_W-1:0] r_s2_exp;
  logic [INT_W-1:0] r_s2_frac;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s3_valid, r_s3_inexact;
  logic [OUT_W-1:0] r_s3_data;
  logic [TAG_W-1:0] r_s3_tag;

  logic             w_s1_en, w_s2_en, w_s3_en;
  logic [INT_W-1:0] w_s1_mag;
  logic [EXP_W-1:0] w_s2_p, w_s2_exp, w_s2_sh;
  logic             w_s2_nz;
  logic [INT_W-1:0] w_s2_frac;
  logic [FR_W-1:0]  w_s3_frac;
  logic [MAN_W-1:0] w_s3_man_t, w_s3_man;
  logic [EXP_W-1:0] w_s3_exp;
  logic             w_s3_guard, w_s3_sticky;

  // A stage may load when empty or when the stage after it loads in the same cycle.
  assign w_s3_en = ~r_s3_valid | bus.out_ready;
  assign w_s2_en = ~r_s2_valid | w_s3_en;
  assign w_s1_en = ~r_s1_valid | w_s2_en;

  assign bus.in_ready    = w_s1_en & ~rst;
  assign bus.out_valid   = r_s3_valid;
  assign bus.out_data    = r_s3_data;
  assign bus.out_tag     = r_s3_tag;
  assign bus.out_inexact = r_s3_inexact;

  assign w_s1_mag = bus.in_data[INT_W-1] ? -bus.in_data : bus.in_data;

  always_comb begin
    w_s2_p  = '0;
    w_s2_nz = 1'b0;
    for (int unsigned i = 0; i < INT_W; i++) begin
      if (r_s1_mag[i]) begin
        w_s2_p  = EXP_W'(i);
        w_s2_nz = 1'b1;
      end
    end
  end

  // Shifting past the leading one leaves only the fraction bits, MSB-aligned.
  assign w_s2_sh   = EXP_W'(INT_W) - w_s2_p;
  assign w_s2_frac = r_s1_mag << w_s2_sh;
  assign w_s2_exp  = w_s2_nz ? w_s2_p + EXP_W'(1) : '0;

  assign w_s3_frac   = {r_s2_frac, {MAN_W{1'b0}}};
  assign w_s3_man_t  = w_s3_frac[FR_W-1 -: MAN_W];
  assign w_s3_guard  = w_s3_frac[INT_W-1];
  assign w_s3_sticky = |w_s3_frac[INT_W-2:0];

`ifdef INT2FLOAT_ROUND_EN
  logic             w_s3_rnd;
  logic [MAN_W:0]   w_s3_man_sum;
  assign w_s3_rnd     = w_s3_guard & (w_s3_sticky | w_s3_man_t[0]);
  assign w_s3_man_sum = {1'b0, w_s3_man_t} + (MAN_W+1)'(w_s3_rnd);
  // Carry-out wraps the mantissa to zero and bumps the exponent.
  assign w_s3_man     = w_s3_man_sum[MAN_W-1:0];
  assign w_s3_exp     = r_s2_exp + EXP_W'(w_s3_man_sum[MAN_W]);
`else
  assign w_s3_man     = w_s3_man_t;
  assign w_s3_exp     = r_s2_exp;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_sign    <= 1'b0;
      r_s1_mag     <= '0;
      r_s1_tag     <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_sign    <= 1'b0;
      r_s2_exp     <= '0;
      r_s2_frac    <= '0;
      r_s2_tag     <= '0;
      r_s3_valid   <= 1'b0;
      r_s3_data    <= '0;
      r_s3_tag     <= '0;
      r_s3_inexact <= 1'b0;
    end else begin
      if (w_s1_en) begin
        r_s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_sign <= bus.in_data[INT_W-1];
          r_s1_mag  <= w_s1_mag;
          r_s1_tag  <= bus.in_tag;
        end
      end
      if (w_s2_en) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_sign <= r_s1_sign;
          r_s2_exp  <= w_s2_exp;
          r_s2_frac <= w_s2_frac;
          r_s2_tag  <= r_s1_tag;
        end
      end
      if (w_s3_en) begin
        r_s3_valid <= r_s2_valid;
        if (r_s2_valid) begin
          r_s3_data    <= {r_s2_sign, w_s3_exp, w_s3_man};
          r_s3_tag     <= r_s2_tag;
          r_s3_inexact <= w_s3_guard | w_s3_sticky;
        end
      end
    end
  end
endmodule

// File: tb/tb_int2float_pipe.sv
// Bench for int2float_pipe: directed vectors, stall/reset scenarios and a random stream vs. an arithmetic model.
module tb_int2float_pipe;
  localparam int INT_W = 16;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int TAG_W = 4;
  localparam int OUT_W = 1 + EXP_W + MAN_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int2float_pipe_if #(.INT_W(INT_W), .EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

  int2float_pipe #(.INT_W(INT_W), .EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             inex;
    logic [TAG_W-1:0] tag;
    bit               has_k;
    logic [OUT_W-1:0] kdata;
    logic             kinex;
    int               stamp;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               accepts = 0;
  bit               chk_lat = 1'b0;
  bit               stalled = 1'b0;
  logic [OUT_W-1:0] held_data;
  logic [TAG_W-1:0] held_tag;
  logic             held_inex;
  bit               k_set = 1'b0;
  logic [OUT_W-1:0] k_data;
  logic             k_inex;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: value = mag * 2^MAN_W / 2^p, with the remainder deciding inexact/rounding.
  function automatic logic [OUT_W:0] model(input logic [INT_W-1:0] x);
    longint v, mag, scaled, rem, half, m;
    logic   s;
    int     p, e;
    v   = longint'($signed(x));
    s   = (v < 0);
    mag = s ? -v : v;
    if (mag == 0) return '0;
    p = 0;
    while ((64'sd1 <<< (p + 1)) <= mag) p++;
    scaled = (mag <<< MAN_W) >>> p;
    rem    = (mag <<< MAN_W) - (scaled <<< p);
    e      = p + 1;
`ifdef INT2FLOAT_ROUND_EN
    half = (p > 0) ? (64'sd1 <<< (p - 1)) : 64'sd0;
    if (p > 0 && (rem > half || (rem == half && scaled[0]))) scaled++;
    if (scaled == (64'sd1 <<< (MAN_W + 1))) begin
      scaled = 64'sd1 <<< MAN_W;
      e++;
    end
`endif
    m = scaled - (64'sd1 <<< MAN_W);
    return {(rem != 0), s, e[EXP_W-1:0], m[MAN_W-1:0]};
  endfunction

  function automatic logic [INT_W-1:0] pick_word();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // One clock: drive at the falling edge, observe 1 time unit later, scoreboard the upcoming rising edge.
  task automatic cycle(input logic v, input logic [INT_W-1:0] d, input logic [TAG_W-1:0] t,
                       input logic ordy, output bit acc);
    logic [OUT_W:0] r;
    exp_t           e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_tag    = t;
    bus.out_ready = ordy;
    #1;
    if (stalled) begin
      check("stall_data", bus.out_data, held_data);
      check("stall_tag", bus.out_tag, held_tag);
      check("stall_inexact", bus.out_inexact, held_inex);
    end
    if (bus.out_valid && ordy) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL spurious_output observed=%h expected=none", bus.out_data);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("data", bus.out_data, e.data);
        check("tag", bus.out_tag, e.tag);
        check("inexact", bus.out_inexact, e.inex);
        if (e.has_k) begin
          check("directed_data", bus.out_data, e.kdata);
          check("directed_inexact", bus.out_inexact, e.kinex);
        end
        if (chk_lat) check("latency", cyc - e.stamp, 3);
      end
    end
    stalled   = bus.out_valid && !ordy;
    held_data = bus.out_data;
    held_tag  = bus.out_tag;
    held_inex = bus.out_inexact;
    acc = v && bus.in_ready;
    if (acc) begin
      r       = model(d);
      e.data  = r[OUT_W-1:0];
      e.inex  = r[OUT_W];
      e.tag   = t;
      e.has_k = k_set;
      e.kdata = k_data;
      e.kinex = k_inex;
      e.stamp = cyc;
      sb.push_back(e);
      k_set = 1'b0;
      accepts++;
    end
    cyc++;
  endtask

  task automatic send_k(input logic [INT_W-1:0] d, input logic [TAG_W-1:0] t,
                        input logic [OUT_W-1:0] kd, input logic ki);
    bit acc;
    k_set  = 1'b1;
    k_data = kd;
    k_inex = ki;
    cycle(1'b1, d, t, 1'b1, acc);
    check("directed_accept", acc, 1);
    k_set = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while (sb.size() > 0 && n < 300) begin
      cycle(1'b0, '0, '0, 1'b1, acc);
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    bit               acc;
    bit               v, r;
    int               sent, n;
    logic [INT_W-1:0] pend_d;
    logic [TAG_W-1:0] pend_t;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_out_tag", bus.out_tag, 0);
    check("reset_out_inexact", bus.out_inexact, 0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", bus.in_ready, 1);

    chk_lat = 1'b1;
    send_k(16'h0000, 4'h1, 16'h0000, 1'b0);
    send_k(16'h0001, 4'h2, 16'h0400, 1'b0);
    send_k(16'hFFFF, 4'h3, 16'h8400, 1'b0);
    send_k(16'h0003, 4'h4, 16'h0A00, 1'b0);
    drain();

    send_k(16'h8000, 4'h5, 16'hC000, 1'b0);
`ifdef INT2FLOAT_ROUND_EN
    send_k(16'h7FFF, 4'h6, 16'h4000, 1'b1);
    send_k(16'h0801, 4'h7, 16'h3000, 1'b1);
    send_k(16'h0803, 4'h8, 16'h3002, 1'b1);
`else
    send_k(16'h7FFF, 4'h6, 16'h3FFF, 1'b1);
    send_k(16'h0801, 4'h7, 16'h3000, 1'b1);
    send_k(16'h0803, 4'h8, 16'h3001, 1'b1);
`endif
    drain();
    chk_lat = 1'b0;

    accepts = 0;
    pend_d  = pick_word();
    pend_t  = 4'($urandom);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, pend_d, pend_t, 1'b0, acc);
      if (acc) begin
        pend_d = pick_word();
        pend_t = 4'($urandom);
      end
    end
    check("stall_accepts", accepts, 3);
    check("stall_in_ready", bus.in_ready, 0);
    sent = accepts;
    n    = 0;
    while (sent < 20 && n < 200) begin
      cycle(1'b1, pend_d, pend_t, 1'b1, acc);
      if (acc) begin
        sent++;
        pend_d = pick_word();
        pend_t = 4'($urandom);
      end
      n++;
    end
    check("stall_stream_sent", sent, 20);
    drain();

    cycle(1'b1, 16'h1234, 4'h5, 1'b1, acc);
    cycle(1'b1, 16'hF00D, 4'h6, 1'b1, acc);
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h0101;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    stalled = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    repeat (6) cycle(1'b0, '0, '0, 1'b1, acc);
    chk_lat = 1'b1;
`ifdef INT2FLOAT_ROUND_EN
    send_k(16'h0803, 4'h9, 16'h3002, 1'b1);
`else
    send_k(16'h0803, 4'h9, 16'h3001, 1'b1);
`endif
    drain();
    chk_lat = 1'b0;

    sent   = 0;
    n      = 0;
    pend_d = pick_word();
    pend_t = 4'($urandom);
    while (sent < 10000 && n < 60000) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      cycle(v, pend_d, pend_t, r, acc);
      if (acc) begin
        sent++;
        pend_d = pick_word();
        pend_t = 4'($urandom);
      end
      n++;
    end
    check("random_sent", sent, 10000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
